// File: rtl/demux_1x8.sv
// 1-to-8 demultiplexer: the enable and a one-hot decode of s steer y onto a single lane.
// All other lanes are zero. The output is registered (REG_OUT=1) or combinational (REG_OUT=0).
module demux_1x8 #(
   parameter int DATA_W  = 1,
   parameter bit REG_OUT = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [8*DATA_W-1:0]   i,
   input  logic [2:0]            s,
   input  logic                  e,
   input  logic [DATA_W-1:0]     y
);

   logic [7:0][DATA_W-1:0] i_d;
   logic [7:0]             sel_oh;

   // Each lane gates y with its own bit of the decoded select.
   // This keeps at most one lane non-zero.
   for (genvar k = 0; k < 8; k++) begin : g_lane
      assign sel_oh[k] = e && (s == 3'(k));
   end

   always_comb begin
      i_d = '0;
      for (int k = 0; k < 8; k++) begin
         if (sel_oh[k]) i_d[k] = y;
      end
   end

   if (REG_OUT) begin : g_reg
      logic [7:0][DATA_W-1:0] i_q;

      always_ff @(posedge clk) begin
         if (rst) i_q <= '0;
         else     i_q <= i_d;
      end

      assign i = i_q;
   end else begin : g_comb
      assign i = i_d;
   end

endmodule

// File: tb/tb_demux_1x8.sv
// Directed bench for demux_1x8 (DATA_W=1, REG_OUT=1).
// Each task drives its own stimulus and checks the registered output against hand-computed values.
module tb_demux_1x8;

   logic       clk;
   logic       rst;
   logic [7:0] i;
   logic [2:0] s;
   logic       e;
   logic       y;

   int total = 0;
   int bad   = 0;

   demux_1x8 #(.DATA_W(1), .REG_OUT(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .i   (i),
      .s   (s),
      .e   (e),
      .y   (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle. Inputs are changed only at this point,
   // which is well away from the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; e = 1'b1; s = 3'd5; y = 1'b1;
      for (int n = 0; n < 2; n++) begin
         tick();
         total++;
         if (i !== 8'h00) begin
            bad++;
            $display("FAIL reset_hold[%0d] got=%h exp=%h", n, i, 8'h00);
         end
      end
      rst = 1'b0;
      tick();
      total++;
      if (i !== 8'h20) begin
         bad++;
         $display("FAIL reset_release got=%h exp=%h", i, 8'h20);
      end
   endtask

   task automatic test_sweep();
      logic [7:0] exp_v [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      e = 1'b1; y = 1'b1;
      for (int k = 0; k < 8; k++) begin
         s = 3'(k);
         tick();
         total++;
         if (i !== exp_v[k]) begin
            bad++;
            $display("FAIL sweep_s%0d got=%h exp=%h", k, i, exp_v[k]);
         end
      end
   endtask

   task automatic test_zero_data();
      e = 1'b1; y = 1'b0; s = 3'd3;
      tick();
      total++;
      if (i !== 8'h00) begin
         bad++;
         $display("FAIL zero_data got=%h exp=%h", i, 8'h00);
      end
      y = 1'b1;
      tick();
      total++;
      if (i !== 8'h08) begin
         bad++;
         $display("FAIL zero_data_then_one got=%h exp=%h", i, 8'h08);
      end
   endtask

   task automatic test_enable();
      e = 1'b0; y = 1'b1; s = 3'd6;
      tick();
      total++;
      if (i !== 8'h00) begin
         bad++;
         $display("FAIL enable_off got=%h exp=%h", i, 8'h00);
      end
      e = 1'b1;
      tick();
      total++;
      if (i !== 8'h40) begin
         bad++;
         $display("FAIL enable_on got=%h exp=%h", i, 8'h40);
      end
      e = 1'b0;
      tick();
      total++;
      if (i !== 8'h00) begin
         bad++;
         $display("FAIL enable_drop_no_hold got=%h exp=%h", i, 8'h00);
      end
   endtask

   task automatic test_random();
      logic [7:0] exp_q;
      e = 1'b1;
      for (int n = 0; n < 10; n++) begin
         if (n % 2 == 0) y = 1'($urandom_range(1, 0));
         else            s = 3'($urandom_range(7, 0));
         // Scoreboard value for what the next edge should load.
         exp_q = y ? (8'h01 << s) : 8'h00;
         tick();
         total++;
         if (i !== exp_q) begin
            bad++;
            $display("FAIL random[%0d] s=%0d y=%0b got=%h exp=%h", n, s, y, i, exp_q);
         end
      end
   endtask

   task automatic test_between_edges();
      e = 1'b1; y = 1'b1; s = 3'd2;
      tick();
      total++;
      if (i !== 8'h04) begin
         bad++;
         $display("FAIL mid_setup got=%h exp=%h", i, 8'h04);
      end
      #2;
      s = 3'd7;
      #1;
      total++;
      if (i !== 8'h04) begin
         bad++;
         $display("FAIL mid_s_change got=%h exp=%h", i, 8'h04);
      end
      y = 1'b0;
      #1;
      y = 1'b1;
      total++;
      if (i !== 8'h04) begin
         bad++;
         $display("FAIL mid_y_change got=%h exp=%h", i, 8'h04);
      end
      tick();
      total++;
      if (i !== 8'h80) begin
         bad++;
         $display("FAIL mid_next_edge got=%h exp=%h", i, 8'h80);
      end
   endtask

   task automatic test_reset_mid_op();
      e = 1'b1; y = 1'b1; s = 3'd1;
      tick();
      rst = 1'b1;
      tick();
      total++;
      if (i !== 8'h00) begin
         bad++;
         $display("FAIL midop_reset got=%h exp=%h", i, 8'h00);
      end
      rst = 1'b0; s = 3'd4;
      tick();
      total++;
      if (i !== 8'h10) begin
         bad++;
         $display("FAIL midop_release got=%h exp=%h", i, 8'h10);
      end
   endtask

   initial begin
      rst = 1'b1; e = 1'b0; s = 3'd0; y = 1'b0;
      #1;
      test_reset();
      test_sweep();
      test_zero_data();
      test_enable();
      test_random();
      test_between_edges();
      test_reset_mid_op();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
